add_frac_stage: RTL and testbench

- Parametrised, pipelined successor to the FP16 step-2 fraction adder: signed-magnitude fraction addition across LANES independent lanes per transaction.
- Adds per-lane add/subtract mode, IEEE-correct zero-sum sign, a zero flag, and valid/ready flow control with a 2-entry skid buffer for full throughput under back-pressure.
- Sits between exponent-align (step 1) and normalise/round (step 3) in the systolic MAC add path.

---
 rtl/add_frac_pkg.sv | 23 ++
 rtl/add_frac_lane.sv | 42 ++++
 rtl/add_frac_stage.sv | 122 ++++++++++++
 tb/tb_add_frac_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_frac_pkg.sv
// add_frac_pkg: shared widths and per-lane result bundle
// for the signed-magnitude fraction adder stage.
package add_frac_pkg;

    localparam int FRAC_W_DEF = 13;
    localparam int EXP_W_DEF  = 5;

    // Per-lane registered result.
    // Field order matches the flattened layout in the top.
    typedef struct packed {
        logic                  sign;
        logic                  carry;
        logic                  zero;
        logic [FRAC_W_DEF-1:0] sum;
        logic [EXP_W_DEF-1:0]  exp;
    } lane_res_t;

    // Width of one flattened lane_res_t for arbitrary widths.
    function automatic int res_w(int frac_w, int exp_w);
        return 3 + frac_w + exp_w;
    endfunction

endpackage

// File: rtl/add_frac_lane.sv
// add_frac_lane: combinational signed-magnitude add/sub, one lane.
// in: frac1/sign1, frac2/sign2, op_sub; out: sign_out, carry_out, zero_out, sum
module add_frac_lane #(
    parameter int FRAC_W = 13
) (
    input  logic [FRAC_W-1:0] frac1,
    input  logic              sign1,
    input  logic [FRAC_W-1:0] frac2,
    input  logic              sign2,
    input  logic              op_sub,
    output logic              sign_out,
    output logic              carry_out,
    output logic              zero_out,
    output logic [FRAC_W-1:0] sum
);

    localparam int W = FRAC_W + 2;

    logic          eff_sign2;
    logic          neg;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  s;
    logic [FRAC_W:0] mag;

    always_comb begin
        eff_sign2 = sign2 ^ op_sub;
        a = sign1 ? -{2'b00, frac1} : {2'b00, frac1};
        b = eff_sign2 ? -{2'b00, frac2} : {2'b00, frac2};
        s = a + b;
        neg = s[W-1];
        // |s| < 2^(FRAC_W+1), so negating the low bits is exact
        mag = (s[FRAC_W:0] ^ {(FRAC_W+1){neg}})
            + {{FRAC_W{1'b0}}, neg};
        zero_out = (s == '0);
        // Only -0 + -0 keeps a negative zero
        sign_out = zero_out ? (sign1 & eff_sign2) : neg;
        carry_out = mag[FRAC_W];
        sum = mag[FRAC_W-1:0];
    end

endmodule

// File: rtl/add_frac_stage.sv
// add_frac_stage: LANES-wide fraction adder, 1-cycle latency,
// valid/ready with primary + skid register.
// in: clk, rst, in_valid, frac1/2, sign1/2, op_sub, exp_max_in, out_ready
// out: in_ready, out_valid, sign_out, sum, carry_out, zero_out, exp_max_out
module add_frac_stage
    import add_frac_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int EXP_W  = EXP_W_DEF,
    parameter int LANES  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*FRAC_W-1:0] frac1,
    input  logic [LANES-1:0]       sign1,
    input  logic [LANES*FRAC_W-1:0] frac2,
    input  logic [LANES-1:0]       sign2,
    input  logic [LANES-1:0]       op_sub,
    input  logic [LANES*EXP_W-1:0] exp_max_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       sign_out,
    output logic [LANES*FRAC_W-1:0] sum,
    output logic [LANES-1:0]       carry_out,
    output logic [LANES-1:0]       zero_out,
    output logic [LANES*EXP_W-1:0] exp_max_out
);

    localparam int RES_W = res_w(FRAC_W, EXP_W);
    localparam int BUS_W = LANES * RES_W;

    logic [BUS_W-1:0] new_d;
    logic [BUS_W-1:0] prim_d;
    logic [BUS_W-1:0] skid_d;
    logic [BUS_W-1:0] prim_n;
    logic [BUS_W-1:0] skid_n;
    logic             prim_v;
    logic             skid_v;
    logic             prim_v_n;
    logic             skid_v_n;
    logic             ready_q;
    logic             accept;
    logic             drain;
    logic             prim_free;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic              l_sign;
        logic              l_carry;
        logic              l_zero;
        logic [FRAC_W-1:0] l_sum;

        add_frac_lane #(.FRAC_W(FRAC_W)) u_lane (
            .frac1     (frac1[i*FRAC_W +: FRAC_W]),
            .sign1     (sign1[i]),
            .frac2     (frac2[i*FRAC_W +: FRAC_W]),
            .sign2     (sign2[i]),
            .op_sub    (op_sub[i]),
            .sign_out  (l_sign),
            .carry_out (l_carry),
            .zero_out  (l_zero),
            .sum       (l_sum)
        );

        assign new_d[i*RES_W +: RES_W] =
            {l_sign, l_carry, l_zero, l_sum,
             exp_max_in[i*EXP_W +: EXP_W]};

        assign {sign_out[i], carry_out[i], zero_out[i],
                sum[i*FRAC_W +: FRAC_W],
                exp_max_out[i*EXP_W +: EXP_W]} =
            prim_d[i*RES_W +: RES_W];
    end

    assign in_ready  = ready_q;
    assign out_valid = prim_v;
    assign accept    = in_valid & ready_q;
    assign drain     = prim_v & out_ready;
    assign prim_free = !prim_v || drain;

    always_comb begin
        prim_n   = prim_d;
        skid_n   = skid_d;
        prim_v_n = prim_v;
        skid_v_n = skid_v;
        unique case (1'b1)
            // ready_q is low while the skid is full: no accept here
            prim_free && skid_v: begin
                prim_n   = skid_d;
                skid_v_n = 1'b0;
            end
            prim_free && !skid_v: begin
                prim_v_n = accept;
                if (accept) prim_n = new_d;
            end
            default: begin
                if (accept) begin
                    skid_n   = new_d;
                    skid_v_n = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prim_v  <= 1'b0;
            skid_v  <= 1'b0;
            ready_q <= 1'b0;
            prim_d  <= '0;
            skid_d  <= '0;
        end else begin
            prim_v  <= prim_v_n;
            skid_v  <= skid_v_n;
            prim_d  <= prim_n;
            skid_d  <= skid_n;
            ready_q <= !skid_v_n;
        end
    end

endmodule

// File: tb/tb_add_frac_stage.sv
// tb_add_frac_stage: directed + random checks of add_frac_stage
// against an integer-arithmetic reference and FIFO scoreboard.
module tb_add_frac_stage;

    localparam int FW = 13;
    localparam int EW = 5;
    localparam int L  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [L*FW-1:0] frac1;
    logic [L-1:0]    sign1;
    logic [L*FW-1:0] frac2;
    logic [L-1:0]    sign2;
    logic [L-1:0]    op_sub;
    logic [L*EW-1:0] exp_max_in;
    logic            out_valid;
    logic            out_ready;
    logic [L-1:0]    sign_out;
    logic [L*FW-1:0] sum;
    logic [L-1:0]    carry_out;
    logic [L-1:0]    zero_out;
    logic [L*EW-1:0] exp_max_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;

    logic [83:0] exp_q[$];
    logic [83:0] held;
    logic [83:0] e;
    bit          stall_prev = 1'b0;
    bit          acc;
    bit          saw_low;
    int          sent;
    int          sent_low;
    int          out_mark;

    add_frac_stage #(.FRAC_W(FW), .EXP_W(EW), .LANES(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .frac1       (frac1),
        .sign1       (sign1),
        .frac2       (frac2),
        .sign2       (sign2),
        .op_sub      (op_sub),
        .exp_max_in  (exp_max_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sign_out    (sign_out),
        .sum         (sum),
        .carry_out   (carry_out),
        .zero_out    (zero_out),
        .exp_max_out (exp_max_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Signed integer reference: add the two signed operands directly.
    function automatic logic [83:0] model(
        logic [L*FW-1:0] f1, logic [L-1:0] s1,
        logic [L*FW-1:0] f2, logic [L-1:0] s2,
        logic [L-1:0] os, logic [L*EW-1:0] ex);
        logic [L-1:0]    sg;
        logic [L-1:0]    cy;
        logic [L-1:0]    zr;
        logic [L*FW-1:0] sm;
        for (int i = 0; i < L; i++) begin
            int   v1;
            int   v2;
            int   s;
            int   m;
            logic e2;
            e2 = s2[i] ^ os[i];
            v1 = int'(f1[i*FW +: FW]);
            v2 = int'(f2[i*FW +: FW]);
            if (s1[i]) v1 = -v1;
            if (e2) v2 = -v2;
            s = v1 + v2;
            m = (s < 0) ? -s : s;
            sm[i*FW +: FW] = m[FW-1:0];
            cy[i] = m[FW];
            zr[i] = (s == 0);
            sg[i] = (s == 0) ? (s1[i] & e2) : (s < 0);
        end
        return {sg, cy, zr, sm, ex};
    endfunction

    function automatic logic [83:0] cur();
        return {sign_out, carry_out, zero_out, sum, exp_max_out};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_in();
        for (int i = 0; i < L; i++) begin
            frac1[i*FW +: FW] = FW'($urandom_range(0, 8191));
            frac2[i*FW +: FW] = FW'($urandom_range(0, 8191));
            exp_max_in[i*EW +: EW] = EW'($urandom_range(0, 31));
        end
        sign1  = L'($urandom_range(0, 15));
        sign2  = L'($urandom_range(0, 15));
        op_sub = L'($urandom_range(0, 15));
    endtask

    task automatic drive0(logic [FW-1:0] f1, logic s1,
                          logic [FW-1:0] f2, logic s2,
                          logic os, logic [EW-1:0] ex);
        rand_in();
        frac1[FW-1:0]  = f1;
        frac2[FW-1:0]  = f2;
        sign1[0]       = s1;
        sign2[0]       = s2;
        op_sub[0]      = os;
        exp_max_in[EW-1:0] = ex;
    endtask

    // Scoreboard: push on accept, pop and compare on consume,
    // and check that stalled outputs hold.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) chk("hold_stable", cur(), held);
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    chk("fifo_data", cur(), exp_q.pop_front());
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(frac1, sign1, frac2, sign2,
                                      op_sub, exp_max_in));
            stall_prev = out_valid && !out_ready;
            held = cur();
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        rand_in();

        // Reset held for three cycles with in_valid high
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_data", cur(), 0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // Directed lane-0 arithmetic
        in_valid = 1'b1;
        drive0(13'h1000, 0, 13'h1000, 0, 0, 5'h03);
        step();
        chk("d1_valid", out_valid, 1);
        chk("d1_sum", sum[FW-1:0], 13'h0000);
        chk("d1_carry", carry_out[0], 1);
        chk("d1_sign", sign_out[0], 0);
        chk("d1_zero", zero_out[0], 0);

        drive0(13'h0800, 0, 13'h0A00, 1, 0, 5'h07);
        step();
        chk("d2_sum", sum[FW-1:0], 13'h0200);
        chk("d2_sign", sign_out[0], 1);
        chk("d2_carry", carry_out[0], 0);

        drive0(13'h0400, 0, 13'h0400, 0, 1, 5'h11);
        step();
        chk("d3_sum", sum[FW-1:0], 13'h0000);
        chk("d3_zero", zero_out[0], 1);
        chk("d3_sign", sign_out[0], 0);

        drive0(13'h0000, 1, 13'h0000, 1, 0, 5'h1E);
        step();
        chk("negzero_zero", zero_out[0], 1);
        chk("negzero_sign", sign_out[0], 1);
        chk("negzero_exp", exp_max_out[EW-1:0], 5'h1E);

        drive0(13'h0123, 1, 13'h0123, 0, 0, 5'h1E);
        step();
        chk("poszero_zero", zero_out[0], 1);
        chk("poszero_sign", sign_out[0], 0);
        chk("poszero_exp", exp_max_out[EW-1:0], 5'h1E);

        in_valid = 1'b0;
        step();
        step();
        chk("idle_valid", out_valid, 0);

        // Back-pressure: out_ready low on cycles 2..5
        sent = 0;
        saw_low = 1'b0;
        sent_low = -1;
        rand_in();
        for (int c = 0; c < 40 && (sent < 8 || exp_q.size() > 0); c++) begin
            out_ready = !(c >= 2 && c <= 5);
            in_valid = (sent < 8);
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                sent++;
                rand_in();
            end
            if (!in_ready && !saw_low) begin
                saw_low = 1'b1;
                sent_low = sent;
            end
        end
        chk("bp_ready_dropped", saw_low, 1);
        chk("bp_sent_at_drop", sent_low, 3);
        chk("bp_sent_all", sent, 8);
        chk("bp_drained", exp_q.size(), 0);

        // Full throughput, latency 1
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            rand_in();
            e = model(frac1, sign1, frac2, sign2, op_sub, exp_max_in);
            step();
            chk("tp_valid", out_valid, 1);
            chk("tp_ready", in_ready, 1);
            chk("tp_data", cur(), e);
        end
        in_valid = 1'b0;
        step();
        chk("tp_drained", exp_q.size(), 0);

        // Mid-stream reset with primary and skid full
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_in();
        step();
        rand_in();
        step();
        in_valid = 1'b0;
        chk("mr_full_valid", out_valid, 1);
        chk("mr_full_ready", in_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("mr_rst_valid", out_valid, 0);
        chk("mr_rst_data", cur(), 0);
        step();
        chk("mr_post_valid", out_valid, 0);
        chk("mr_post_ready", in_ready, 1);
        out_mark = n_out;
        in_valid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            rand_in();
            step();
        end
        in_valid = 1'b0;
        for (int t = 0; t < 5 && exp_q.size() > 0; t++) step();
        step();
        chk("mr_new_count", n_out - out_mark, 3);
        chk("mr_drained", exp_q.size(), 0);
        chk("mr_idle", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
